stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_pkg.sv | 45 ++++
 rtl/stopwatch_core_bcd_digit.sv | 37 +++
 rtl/stopwatch_core.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and 7-segment constants for the stopwatch core.
// Optional lap-freeze display is enabled in stopwatch_core with STOPWATCH_LAP_EN.
package stopwatch_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } sw_state_e;

  // Active-low segment patterns, bit 0 = a ... bit 6 = g.
  localparam logic [SEG_W-1:0] SEG_DIGIT0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_DIGIT1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_DIGIT2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_DIGIT3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_DIGIT4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_DIGIT5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_DIGIT6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_DIGIT7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_DIGIT8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DIGIT9 = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_DIGIT0;
      4'd1:    s = SEG_DIGIT1;
      4'd2:    s = SEG_DIGIT2;
      4'd3:    s = SEG_DIGIT3;
      4'd4:    s = SEG_DIGIT4;
      4'd5:    s = SEG_DIGIT5;
      4'd6:    s = SEG_DIGIT6;
      4'd7:    s = SEG_DIGIT7;
      4'd8:    s = SEG_DIGIT8;
      4'd9:    s = SEG_DIGIT9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One decade of the stopwatch counter; carry flags terminal count (9) so the
// ripple enables are formed from register state only.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] q,
  output logic             carry
);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  assign carry = (q_q == 4'd9);
  assign q     = q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      q_d = carry ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch: synchronised buttons, IDLE/RUN/STOP control, BCD count and
// multiplexed 7-segment scan. Define STOPWATCH_LAP_EN for the lap-freeze display.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 1_000_000,
  parameter int unsigned REFRESH_DIV = 100_000,
  parameter int unsigned DP_POS      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  lap,
  output logic [SEG_W-1:0]      seg,
  output logic                  decimal,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  running,
  output logic                  overflow
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned SW = $clog2(NUM_DIGITS);
  localparam int unsigned CW = NUM_DIGITS * BCD_W;

  // Two synchroniser flops plus one edge-history flop per button.
  logic [2:0] start_sync_q;
  logic [2:0] lap_sync_q;
  logic       start_pulse_c;
  logic       lap_pulse_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      start_sync_q <= '0;
      lap_sync_q   <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start};
      lap_sync_q   <= {lap_sync_q[1:0], lap};
    end
  end

  assign start_pulse_c = start_sync_q[1] & ~start_sync_q[2];
  assign lap_pulse_c   = lap_sync_q[1] & ~lap_sync_q[2];

  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic          strobe_c;
  logic [RW-1:0] ref_q;
  logic [RW-1:0] ref_d;
  logic [SW-1:0] scan_q;
  logic [SW-1:0] scan_d;

  assign strobe_c = (tick_q == TW'(TICK_DIV - 1));
  assign tick_d   = strobe_c ? '0 : tick_q + TW'(1);

  always_comb begin
    ref_d  = ref_q + RW'(1);
    scan_d = scan_q;
    if (ref_q == RW'(REFRESH_DIV - 1)) begin
      ref_d  = '0;
      scan_d = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
      ref_q  <= '0;
      scan_q <= '0;
    end else begin
      tick_q <= tick_d;
      ref_q  <= ref_d;
      scan_q <= scan_d;
    end
  end

  sw_state_e state_q;
  logic      clr_c;
  logic      inc_c;

  assign clr_c = lap_pulse_c & ~start_pulse_c & (state_q == ST_STOP);
  assign inc_c = strobe_c & (state_q == ST_RUN);

`ifdef STOPWATCH_LAP_EN
  logic freeze_q;
`endif

  // Start wins over lap; any state change drops the lap freeze.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
`ifdef STOPWATCH_LAP_EN
      freeze_q <= 1'b0;
`endif
    end else if (start_pulse_c) begin
`ifdef STOPWATCH_LAP_EN
      freeze_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN:  state_q <= ST_STOP;
        ST_STOP: state_q <= ST_RUN;
        default: state_q <= ST_IDLE;
      endcase
    end else if (lap_pulse_c) begin
      if (state_q == ST_STOP) begin
        state_q  <= ST_IDLE;
`ifdef STOPWATCH_LAP_EN
        freeze_q <= 1'b0;
      end else if (state_q == ST_RUN) begin
        freeze_q <= ~freeze_q;
`endif
      end
    end
  end

  logic [CW-1:0]         count_w;
  logic [NUM_DIGITS-1:0] nine_w;
  logic [NUM_DIGITS-1:0] dig_inc_w;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    if (g == 0) begin : g_lsd
      assign dig_inc_w[g] = inc_c;
    end else begin : g_upper
      assign dig_inc_w[g] = inc_c & (&nine_w[g-1:0]);
    end
    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_c),
      .inc   (dig_inc_w[g]),
      .q     (count_w[g*BCD_W +: BCD_W]),
      .carry (nine_w[g])
    );
  end

  logic overflow_q;

  always_ff @(posedge clk) begin
    if (reset || clr_c) begin
      overflow_q <= 1'b0;
    end else if (inc_c && (&nine_w)) begin
      overflow_q <= 1'b1;
    end
  end

  logic [CW-1:0] disp_w;

`ifdef STOPWATCH_LAP_EN
  logic [CW-1:0] snap_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snap_q <= '0;
    end else if (lap_pulse_c && !start_pulse_c && (state_q == ST_RUN) && !freeze_q) begin
      snap_q <= count_w;
    end
  end

  assign disp_w = freeze_q ? snap_q : count_w;
`else
  assign disp_w = count_w;
`endif

  logic [BCD_W-1:0] disp_digit_c;

  always_comb begin
    disp_digit_c = '1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == SW'(i)) begin
        disp_digit_c = disp_w[i*BCD_W +: BCD_W];
      end
    end
  end

  assign seg      = seg_encode(disp_digit_c);
  assign digit_en = ~(NUM_DIGITS'(1) << scan_q);
  assign decimal  = ~(scan_q == SW'(DP_POS));
  assign running  = (state_q == ST_RUN);
  assign overflow = overflow_q;

endmodule
